// File: rtl/axi_lite_master.sv
`timescale 1ns/1ps
// axi_lite_master
// Single-outstanding AXI4-Lite master. Converts a simple command/response
// handshake into one AXI4-Lite write (AW+W, then B) or read (AR, then R)
// transaction at a time, with an optional per-transaction abort timeout.
//
// Ports
//   m_axi_aclk, m_axi_areset : clock, asynchronous active-high reset
//   cmd_*                    : command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                    : response out (valid/ready, rdata, resp, timeout)
//   busy                     : high whenever the FSM is not IDLE
//   m_axi_*                  : AXI4-Lite master channels AW, W, B, AR, R
//
// Every output is a flop: the next-state process computes next values for
// the outputs together with the state, and one register process stores them.
module axi_lite_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_TIMEOUT_CYCLES   = 256
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_areset,
    // command interface
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    // response interface
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,
    // AXI4-Lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    // AXI4-Lite write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    // AXI4-Lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    // AXI4-Lite read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    // Keep the counter at least one bit wide even when the timeout is disabled.
    localparam int CNT_W  = (C_TIMEOUT_CYCLES < 1) ? 1 : $clog2(C_TIMEOUT_CYCLES + 1);
    localparam bit              TO_EN  = (C_TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(C_TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t                    state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d, cnt_inc;
    logic                      to_hit;
    logic                      aw_pend, w_pend;

    logic                      cmd_ready_d, rsp_valid_d, rsp_timeout_d, busy_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_d, wdata_d;
    logic [1:0]                rsp_resp_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_d, araddr_d;
    logic [STRB_W-1:0]         wstrb_d;
    logic                      awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // Saturating count of cycles spent waiting on the slave. Once saturated,
    // any later phase that is still waiting aborts on its next cycle.
    assign cnt_inc = (cnt == TO_MAX) ? cnt : cnt + CNT_W'(1);
    assign to_hit  = TO_EN && (cnt_inc == TO_MAX);

    // AW and W retire independently; a channel is pending while its valid is
    // up and the slave has not taken it this cycle.
    assign aw_pend = m_axi_awvalid && !m_axi_awready;
    assign w_pend  = m_axi_wvalid  && !m_axi_wready;

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        cmd_ready_d   = cmd_ready;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        awaddr_d      = m_axi_awaddr;
        araddr_d      = m_axi_araddr;
        wdata_d       = m_axi_wdata;
        wstrb_d       = m_axi_wstrb;
        awvalid_d     = m_axi_awvalid;
        wvalid_d      = m_axi_wvalid;
        bready_d      = m_axi_bready;
        arvalid_d     = m_axi_arvalid;
        rready_d      = m_axi_rready;

        unique case (state)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    cnt_d       = '0;
                    awaddr_d    = cmd_addr;
                    araddr_d    = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end

            WR: begin
                cnt_d     = cnt_inc;
                awvalid_d = aw_pend;
                wvalid_d  = w_pend;
                if (!aw_pend && !w_pend) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else if (to_hit) begin
                    awvalid_d     = 1'b0;
                    wvalid_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = 2'b11;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = RESP;
                end
            end

            WR_RESP: begin
                cnt_d = cnt_inc;
                if (m_axi_bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axi_bresp;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = '0;
                    state_d       = RESP;
                end else if (to_hit) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = 2'b11;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = RESP;
                end
            end

            RD_ADDR: begin
                cnt_d = cnt_inc;
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else if (to_hit) begin
                    arvalid_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = 2'b11;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = RESP;
                end
            end

            RD_DATA: begin
                cnt_d = cnt_inc;
                if (m_axi_rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axi_rresp;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = m_axi_rdata;
                    state_d       = RESP;
                end else if (to_hit) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = 2'b11;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = RESP;
                end
            end

            RESP: begin
                // Counter is frozen here: a slow consumer never times out.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state         <= IDLE;
            cnt           <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            busy          <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            cmd_ready     <= cmd_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            rsp_timeout   <= rsp_timeout_d;
            busy          <= busy_d;
            m_axi_awaddr  <= awaddr_d;
            m_axi_araddr  <= araddr_d;
            m_axi_wdata   <= wdata_d;
            m_axi_wstrb   <= wstrb_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
// tb_axi_lite_master
// Directed scenarios plus randomized transactions against a behavioural
// AXI4-Lite slave with per-transaction delays/hangs, checked against a
// word-level reference memory and response rules.
module tb_axi_lite_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_master #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_TIMEOUT_CYCLES  (8)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration for the current transaction.
    // hang: 0 none, 1 AW, 2 W, 3 B, 4 AR, 5 R never answered.
    int         c_daw, c_dw, c_db, c_dar, c_dr, c_hang;
    logic [1:0] c_resp;
    int         txn_id = 0;

    // Count of AW handshakes seen on the bus.
    int aw_hs = 0;
    always @(posedge clk) if (awvalid && awready) aw_hs <= aw_hs + 1;

    // Behavioural slave: decides ready/valid on the falling edge.
    initial begin : slave
        logic [DW-1:0] smem [4];
        int  seen, aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit  aw_got, w_got, b_sent, ar_got, r_sent, committed;
        logic [AW-1:0] s_aw, s_ar;
        logic [DW-1:0] s_wd;
        logic [SW-1:0] s_ws;
        for (int i = 0; i < 4; i++) smem[i] = '0;
        seen = -1;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_sent = 0; ar_got = 0; r_sent = 0; committed = 0;
        s_aw = 0; s_ar = 0; s_wd = 0; s_ws = 0;
        forever begin
            @(negedge clk);
            if (txn_id != seen) begin
                seen = txn_id;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; b_sent = 0; ar_got = 0; r_sent = 0; committed = 0;
            end
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            if (awvalid && !aw_got) begin
                if (c_hang != 1 && aw_cnt == c_daw) begin
                    awready = 1; aw_got = 1; s_aw = awaddr;
                end else aw_cnt++;
            end
            if (wvalid && !w_got) begin
                if (c_hang != 2 && w_cnt == c_dw) begin
                    wready = 1; w_got = 1; s_wd = wdata; s_ws = wstrb;
                end else w_cnt++;
            end
            if (aw_got && w_got && !committed) begin
                committed = 1;
                for (int b = 0; b < SW; b++)
                    if (s_ws[b]) smem[s_aw[3:2]][8*b +: 8] = s_wd[8*b +: 8];
            end
            if (bready && aw_got && w_got && !b_sent) begin
                if (c_hang != 3 && b_cnt == c_db) begin
                    bvalid = 1; bresp = c_resp; b_sent = 1;
                end else b_cnt++;
            end
            if (arvalid && !ar_got) begin
                if (c_hang != 4 && ar_cnt == c_dar) begin
                    arready = 1; ar_got = 1; s_ar = araddr;
                end else ar_cnt++;
            end
            if (rready && ar_got && !r_sent) begin
                if (c_hang != 5 && r_cnt == c_dr) begin
                    rvalid = 1; rdata = smem[s_ar[3:2]]; rresp = c_resp; r_sent = 1;
                end else r_cnt++;
            end
        end
    end

    // Reference model: word memory and expected response of current txn.
    logic [DW-1:0] exp_mem [4];
    logic [DW-1:0] e_rd;
    logic [1:0]    e_rs;
    logic          e_to;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    task automatic send_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
        int k;
        @(negedge clk);
        txn_id++;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        chk("cmd_accept_wait", k < 50, 1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic run_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input int daw, input int dw, input int db,
                           input int dar, input int dr, input int hang, input logic [1:0] resp);
        c_daw = daw; c_dw = dw; c_db = db; c_dar = dar; c_dr = dr; c_hang = hang; c_resp = resp;
        e_to = (hang != 0);
        e_rs = e_to ? 2'b11 : resp;
        if (w) begin
            e_rd = '0;
            if (hang != 1 && hang != 2) exp_mem[a[3:2]] = merge(exp_mem[a[3:2]], d, s);
        end else begin
            e_rd = e_to ? '0 : exp_mem[a[3:2]];
        end
        send_cmd(w, a, d, s);
    endtask

    // Waits for the response, holds rsp_ready low for 'hold' cycles checking
    // the payload each cycle, then completes the handshake.
    task automatic do_rsp(input int hold, input string tag, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 60) begin @(negedge clk); lat++; end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_rdata"}, rsp_rdata, e_rd);
        chk({tag, "_resp"}, rsp_resp, e_rs);
        chk({tag, "_timeout"}, rsp_timeout, e_to);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout},
                {1'b1, e_rd, e_rs, e_to});
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_valid"}, rsp_valid, 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int lat, hs0, k;
        bit w;
        logic [AW-1:0] a;
        int hang;
        for (int i = 0; i < 4; i++) exp_mem[i] = '0;
        c_daw = 0; c_dw = 0; c_db = 0; c_dar = 0; c_dr = 0; c_hang = 0; c_resp = 0;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {cmd_ready, busy, rsp_valid, awvalid, wvalid, bready, arvalid, rready},
            8'h00);
        chk("rst_fields", {awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_timeout}, 0);
        chk("prot", {awprot, arprot}, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_release_ready", cmd_ready, 1);

        // Zero-wait write: AW/W one cycle after acceptance, B one later.
        run_txn(1, 4'h0, 32'h3, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("wr0_awwvalid", {awvalid, wvalid, bready, busy, cmd_ready}, 5'b11010);
        chk("wr0_payload", {awaddr, wdata, wstrb}, {4'h0, 32'h3, 4'hF});
        @(negedge clk);
        chk("wr0_bready", {awvalid, wvalid, bready}, 3'b001);
        do_rsp(0, "wr0", lat);
        chk("wr0_latency", lat, 1);

        // W delayed three cycles after AW completes: exactly one AW handshake.
        hs0 = aw_hs;
        run_txn(1, 4'h8, 32'hA5A5_1234, 4'h5, 0, 3, 0, 0, 0, 0, 2'b00);
        chk("wrd_c1", {awvalid, wvalid}, 2'b11);
        @(negedge clk);
        chk("wrd_c2", {awvalid, wvalid}, 2'b01);
        @(negedge clk);
        chk("wrd_c3", {awvalid, wvalid, wdata}, {2'b01, 32'hA5A5_1234});
        @(negedge clk);
        chk("wrd_c4", {awvalid, wvalid, bready}, 3'b010);
        @(negedge clk);
        chk("wrd_c5", {awvalid, wvalid, bready}, 3'b001);
        do_rsp(0, "wrd", lat);
        chk("wrd_aw_count", aw_hs - hs0, 1);

        // Load 1 at address 4, then read it back after a 2-cycle AR delay.
        run_txn(1, 4'h4, 32'h1, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00);
        do_rsp(0, "wr4", lat);
        run_txn(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 2, 0, 0, 2'b00);
        chk("rd4_arvalid", {arvalid, araddr}, {1'b1, 4'h4});
        k = 0;
        while (!rsp_valid && k < 30) begin
            chk("rd4_cmd_ready_low", cmd_ready, 0);
            @(negedge clk); k++;
        end
        do_rsp(0, "rd4", lat);

        // Zero-wait read latency matches write latency.
        run_txn(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00);
        do_rsp(0, "rd0", lat);
        chk("rd0_latency", lat, 2);

        // AR never accepted: arvalid held 8 cycles, then timeout response.
        run_txn(0, 4'hC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 4, 2'b00);
        k = 0;
        while (arvalid && k < 30) begin k++; @(negedge clk); end
        chk("to_arvalid_cycles", k, 8);
        do_rsp(0, "to", lat);
        chk("to_rsp_immediate", lat, 0);
        run_txn(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00);
        do_rsp(0, "after_to", lat);

        // SLVERR write with a stalled consumer: stable, no timeout.
        run_txn(1, 4'h0, 32'hDEAD_BEEF, 4'h3, 1, 0, 1, 0, 0, 0, 2'b10);
        do_rsp(5, "slverr", lat);

        // Reset while W is pending.
        run_txn(1, 4'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, 0, 2, 2'b00);
        chk("rstw_pending", {wvalid, busy}, 2'b11);
        #2 rst = 1;
        #1 chk("rstw_async", {wvalid, awvalid, busy, cmd_ready, bready}, 5'b0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rstw_ready", cmd_ready, 1);
        run_txn(0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00);
        do_rsp(0, "rstw_read", lat);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            w = 1'($urandom);
            a = 4'($urandom_range(0, 3) << 2);
            hang = 0;
            if ($urandom_range(0, 5) == 0) hang = w ? $urandom_range(1, 3) : $urandom_range(4, 5);
            run_txn(w, a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), hang,
                    2'($urandom));
            do_rsp($urandom_range(0, 3), "rand", lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
